// File: rtl/debug_pkg.sv
// debug_pkg
//   Shared definitions for the CPU-domain debug command executor:
//   opcode values, FSM state encoding and dbg_status bit positions.
package debug_pkg;

  localparam logic [7:0] DEBUGOP_NOOP        = 8'h00;
  localparam logic [7:0] DEBUGOP_HALT        = 8'h01;
  localparam logic [7:0] DEBUGOP_RESUME      = 8'h02;
  localparam logic [7:0] DEBUGOP_RESET       = 8'h03;
  localparam logic [7:0] DEBUGOP_READ        = 8'h04;
  localparam logic [7:0] DEBUGOP_WRITE       = 8'h05;
  localparam logic [7:0] DEBUGOP_CLRERR      = 8'h06;
  localparam logic [7:0] DEBUGOP_STORE_ADDR  = 8'h80;
  localparam logic [7:0] DEBUGOP_STORE_DATA  = 8'h81;
  localparam logic [7:0] DEBUGOP_STORE_CHSEL = 8'h82;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RST  = 2'd2
  } dbg_state_t;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_HALTED  = 1;
  localparam int STAT_OVERRUN = 2;
  localparam int STAT_TIMEOUT = 3;

endpackage

// File: rtl/ff_sync.sv
// ff_sync
//   Two-flop synchroniser for signals crossing into the cpu_clk domain.
//   Ports:
//     cpu_clk   in   destination clock
//     cpu_rstn  in   async active-low reset (flops clear to 0)
//     d         in   WIDTH asynchronous input
//     q         out  WIDTH synchronised output
module ff_sync #(
  parameter int WIDTH = 1
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/debug_exec.sv
// debug_exec
//   CPU-domain debug command executor. Synchronises the JTAG user-op ready
//   strobe, decodes opcodes and drives CPU halt/reset plus an NCH-channel
//   memory access port with req/ack handshake.
//   Optional feature: define DEBUG_AUTOINC_EN to post-increment the address
//   register after every acknowledged READ/WRITE.
//   Ports:
//     cpu_clk, cpu_rstn          clock, async active-low reset
//     jtag_userOp_ready          TCK-domain strobe (asynchronous)
//     jtag_userOp, jtag_userData opcode / operand, stable while ready high
//     cpu_halt, cpu_rst_req      CPU control
//     mem_req/we/addr/wdata      one-hot access request and payload
//     mem_rdata, mem_ack         per-channel read data and completion
//     dbg_rdata, dbg_status      readback: last read, {0,tmo,ovr,halt,busy}
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for exec; only state that accepts ops
//   MEM   | mem_req[chsel] held until ack or timeout
//   RST   | cpu_rst_req high for RST_CYCLES cycles
module debug_exec
  import debug_pkg::*;
#(
  parameter int USER_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NCH        = 2,
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  jtag_userOp_ready,
  input  logic [7:0]            jtag_userOp,
  input  logic [USER_W-1:0]     jtag_userData,
  output logic                  cpu_halt,
  output logic                  cpu_rst_req,
  output logic [NCH-1:0]        mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [NCH*DATA_W-1:0] mem_rdata,
  input  logic [NCH-1:0]        mem_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [7:0]            dbg_status
);

  localparam int CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dbg_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_s, ready_d, exec, busy;
  logic              acc_done, acc_tmo;
  logic              sel_ack;
  logic [DATA_W-1:0] sel_rdata;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdata_q;
  logic [3:0]        chsel_q;
  logic              halt_q, we_q, timeout_err, overrun_err;
  logic              unused_bits;

  assign unused_bits = ^jtag_userData;

  ff_sync #(.WIDTH(1)) u_ready_sync (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .d        (jtag_userOp_ready),
    .q        (ready_s)
  );

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) ready_d <= 1'b0;
    else           ready_d <= ready_s;
  end

  assign exec = ready_s & ~ready_d;
  assign busy = (state_q != ST_IDLE);

  // Channel mux: only the selected channel's ack/rdata are observed.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    mem_req   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (chsel_q == 4'(i)) begin
        sel_ack    = mem_ack[i];
        sel_rdata  = mem_rdata[i*DATA_W +: DATA_W];
        mem_req[i] = (state_q == ST_MEM);
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Down-counter loaded with N-1 so the state lasts exactly N cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_done = 1'b0;
    acc_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exec) begin
          if (jtag_userOp == DEBUGOP_READ || jtag_userOp == DEBUGOP_WRITE) begin
            state_d = ST_MEM;
            cnt_d   = CNT_W'(TIMEOUT - 1);
          end else if (jtag_userOp == DEBUGOP_RESET) begin
            state_d = ST_RST;
            cnt_d   = CNT_W'(RST_CYCLES - 1);
          end
        end
      end
      ST_MEM: begin
        if (sel_ack) begin
          acc_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == '0) begin
          acc_tmo = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RST: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      chsel_q     <= '0;
      halt_q      <= 1'b0;
      we_q        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (exec) begin
        if (busy) begin
          overrun_err <= 1'b1;
        end else begin
          case (jtag_userOp)
            DEBUGOP_HALT:       halt_q <= 1'b1;
            DEBUGOP_RESUME:     halt_q <= 1'b0;
            DEBUGOP_READ:       we_q   <= 1'b0;
            DEBUGOP_WRITE:      we_q   <= 1'b1;
            DEBUGOP_CLRERR: begin
              timeout_err <= 1'b0;
              overrun_err <= 1'b0;
            end
            DEBUGOP_STORE_ADDR: addr_q <= jtag_userData[ADDR_W-1:0];
            DEBUGOP_STORE_DATA: data_q <= jtag_userData[DATA_W-1:0];
            DEBUGOP_STORE_CHSEL: begin
              if ({1'b0, jtag_userData[3:0]} < 5'(NCH)) chsel_q     <= jtag_userData[3:0];
              else                                      overrun_err <= 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (acc_done) begin
        if (!we_q) rdata_q <= sel_rdata;
`ifdef DEBUG_AUTOINC_EN
        addr_q <= addr_q + ADDR_W'(1);
`endif
      end
      if (acc_tmo) timeout_err <= 1'b1;
    end
  end

  assign cpu_halt    = halt_q;
  assign cpu_rst_req = (state_q == ST_RST);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = data_q;
  assign dbg_rdata   = rdata_q;

  always_comb begin
    dbg_status               = '0;
    dbg_status[STAT_BUSY]    = busy;
    dbg_status[STAT_HALTED]  = halt_q;
    dbg_status[STAT_OVERRUN] = overrun_err;
    dbg_status[STAT_TIMEOUT] = timeout_err;
  end

endmodule

// File: tb/tb_debug_exec.sv
module tb_debug_exec;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        jtag_userOp_ready = 1'b0;
  logic [7:0]  jtag_userOp = 8'h00;
  logic [31:0] jtag_userData = 32'h0;
  logic        cpu_halt, cpu_rst_req, mem_we;
  logic [1:0]  mem_req;
  logic [31:0] mem_addr, mem_wdata, dbg_rdata;
  logic [63:0] mem_rdata = 64'h0;
  logic [1:0]  mem_ack = 2'b00;
  logic [7:0]  dbg_status;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 cpu_clk = ~cpu_clk;

  debug_exec dut (
    .cpu_clk           (cpu_clk),
    .cpu_rstn          (cpu_rstn),
    .jtag_userOp_ready (jtag_userOp_ready),
    .jtag_userOp       (jtag_userOp),
    .jtag_userData     (jtag_userData),
    .cpu_halt          (cpu_halt),
    .cpu_rst_req       (cpu_rst_req),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .dbg_rdata         (dbg_rdata),
    .dbg_status        (dbg_status)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Idle gap, raise ready; the op takes effect on the 3rd rising edge.
  // Returns #1 after that edge with ready dropped.
  task automatic send_op(input logic [7:0] op, input logic [31:0] data);
    repeat (3) @(negedge cpu_clk);
    jtag_userOp       = op;
    jtag_userData     = data;
    jtag_userOp_ready = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    jtag_userOp_ready = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] mask);
    @(negedge cpu_clk);
    mem_ack = mask;
    @(posedge cpu_clk);
    #1;
    mem_ack = 2'b00;
  endtask

  initial begin
    repeat (3) @(negedge cpu_clk);
    chk("rst_req", {62'b0, mem_req}, 64'h0);
    chk("rst_status", {56'b0, dbg_status}, 64'h0);
    chk("rst_halt", {63'b0, cpu_halt}, 64'h0);
    chk("rst_rstreq", {63'b0, cpu_rst_req}, 64'h0);
    cpu_rstn = 1'b1;

    // 1: write on channel 1
    send_op(8'h80, 32'h10);
    send_op(8'h81, 32'hCAFE);
    send_op(8'h82, 32'h1);
    send_op(8'h05, 32'h0);
    chk("t1_req", {62'b0, mem_req}, 64'h2);
    chk("t1_we", {63'b0, mem_we}, 64'h1);
    chk("t1_addr", {32'b0, mem_addr}, 64'h10);
    chk("t1_wdata", {32'b0, mem_wdata}, 64'hCAFE);
    chk("t1_busy", {56'b0, dbg_status}, 64'h01);
    do_ack(2'b01);
    chk("t1_wrong_ack", {62'b0, mem_req}, 64'h2);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    mem_ack = 2'b10;
    #1;
    chk("t1_req_in_ack", {62'b0, mem_req}, 64'h2);
    @(posedge cpu_clk);
    #1;
    mem_ack = 2'b00;
    chk("t1_req_drop", {62'b0, mem_req}, 64'h0);
    chk("t1_idle", {56'b0, dbg_status}, 64'h00);
`ifdef DEBUG_AUTOINC_EN
    chk("t1_addr_after", {32'b0, mem_addr}, 64'h11);
`else
    chk("t1_addr_after", {32'b0, mem_addr}, 64'h10);
`endif

    // 2: read on channel 0
    send_op(8'h82, 32'h0);
    mem_rdata = {32'hFFFF_FFFF, 32'h0000_1234};
    send_op(8'h04, 32'h0);
    chk("t2_req", {62'b0, mem_req}, 64'h1);
    chk("t2_we", {63'b0, mem_we}, 64'h0);
    @(negedge cpu_clk);
    do_ack(2'b01);
    chk("t2_rdata", {32'b0, dbg_rdata}, 64'h1234);
    chk("t2_status", {56'b0, dbg_status}, 64'h00);

    send_op(8'h01, 32'h0);
    chk("halt", {63'b0, cpu_halt}, 64'h1);
    chk("halt_status", {56'b0, dbg_status}, 64'h02);

    // 3: timeout
    mem_rdata = {32'hFFFF_FFFF, 32'h0000_9999};
    send_op(8'h04, 32'h0);
    n = 0;
    while (mem_req != 2'b00 && n < 1000) begin
      n++;
      @(posedge cpu_clk);
      #1;
    end
    chk("t3_req_cycles", 64'(n), 64'd255);
    chk("t3_status", {56'b0, dbg_status}, 64'h0A);
    chk("t3_rdata_kept", {32'b0, dbg_rdata}, 64'h1234);
    send_op(8'h06, 32'h0);
    chk("t3_clrerr", {56'b0, dbg_status}, 64'h02);

    // invalid channel select leaves chsel unchanged
    send_op(8'h82, 32'h5);
    chk("chsel_bad", {56'b0, dbg_status}, 64'h06);
    mem_rdata = {32'hFFFF_FFFF, 32'h0000_5678};
    send_op(8'h04, 32'h0);
    chk("chsel_kept", {62'b0, mem_req}, 64'h1);
    do_ack(2'b01);
    chk("chsel_rdata", {32'b0, dbg_rdata}, 64'h5678);
    send_op(8'h06, 32'h0);

    // 4: reset pulse length, halt preserved
    send_op(8'h03, 32'h0);
    n = 0;
    while (cpu_rst_req && n < 1000) begin
      n++;
      @(posedge cpu_clk);
      #1;
    end
    chk("t4_rst_cycles", 64'(n), 64'd16);
    chk("t4_halt_kept", {63'b0, cpu_halt}, 64'h1);
    chk("t4_status", {56'b0, dbg_status}, 64'h02);
    send_op(8'h03, 32'h0);
    send_op(8'h00, 32'h0);
    chk("t4_still_rst", {63'b0, cpu_rst_req}, 64'h1);
    n = 0;
    while (cpu_rst_req && n < 1000) begin
      n++;
      @(posedge cpu_clk);
      #1;
    end
    chk("t4_overrun", {56'b0, dbg_status}, 64'h06);
    send_op(8'h06, 32'h0);
    send_op(8'h02, 32'h0);
    chk("t4_resume", {56'b0, dbg_status}, 64'h00);

    // 5: address wrap
    send_op(8'h80, 32'hFFFF_FFFF);
    send_op(8'h81, 32'hBEEF);
    send_op(8'h82, 32'h1);
    send_op(8'h05, 32'h0);
    chk("t5_addr1", {32'b0, mem_addr}, 64'hFFFF_FFFF);
    do_ack(2'b10);
    send_op(8'h05, 32'h0);
    chk("t5_req2", {62'b0, mem_req}, 64'h2);
`ifdef DEBUG_AUTOINC_EN
    chk("t5_addr2", {32'b0, mem_addr}, 64'h0);
`else
    chk("t5_addr2", {32'b0, mem_addr}, 64'hFFFF_FFFF);
`endif
    do_ack(2'b10);

    // 6: reset mid-access
    send_op(8'h01, 32'h0);
    send_op(8'h04, 32'h0);
    chk("t6_req_before", {62'b0, mem_req}, 64'h2);
    @(negedge cpu_clk);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("t6_req", {62'b0, mem_req}, 64'h0);
    chk("t6_status", {56'b0, dbg_status}, 64'h00);
    chk("t6_halt", {63'b0, cpu_halt}, 64'h0);
    chk("t6_addr", {32'b0, mem_addr}, 64'h0);
    chk("t6_wdata", {32'b0, mem_wdata}, 64'h0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    repeat (10) @(negedge cpu_clk);
    chk("t6_no_exec_req", {62'b0, mem_req}, 64'h0);
    chk("t6_no_exec_status", {56'b0, dbg_status}, 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
